la_wb_master: RTL and testbench

Wishbone B4 classic single-transfer master, commanded from the logic-analyzer bank. Software drives address, data, select and direction on LA inputs and raises a valid; the block runs one Wishbone cycle, then returns read data and a status word on LA outputs. It is the initiator end of the user-project Wishbone slave port, used to exercise user-area slaves without the management SoC. It includes a bounded timeout so a dead slave cannot hang the bench.

---
 rtl/la_wb_pkg.sv | 16 +
 rtl/la_wb_master.sv | 151 +++++++++++++++
 tb/tb_la_wb_master.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_wb_pkg.sv
// Shared types and constants for the logic-analyzer driven Wishbone master.
package la_wb_pkg;

    // Controller states: waiting for a command, running a bus cycle, holding a response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Response status codes reported on rsp_status_o.
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/la_wb_master.sv
// Wishbone B4 classic single-transfer master commanded from logic-analyzer
// signals. One command produces one bus cycle and one held response; a dead
// slave is cut off after TIMEOUT_CYCLES strobe cycles.
module la_wb_master
    import la_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic [1:0]       rsp_status_o,
    output logic [CNT_W-1:0] txn_count_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    input  logic [31:0]      wbm_dat_i
);

    // Last strobe cycle index: the counter starts at 0 in the first BUS cycle.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e             state_q;
    logic               ready_q;
    logic               cyc_q;
    logic               we_q;
    logic [3:0]         sel_q;
    logic [31:0]        adr_q;
    logic [31:0]        dat_q;
    logic               rsp_valid_q;
    logic [31:0]        rsp_dat_q;
    logic [1:0]         rsp_status_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        tmo_q;

    logic [CNT_W-1:0]   cnt_d;
    logic [15:0]        tmo_d;
    logic               tmo_hit_s;

    // Next values of the two counters and the timeout comparison.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        tmo_d     = tmo_q + 16'd1;
        tmo_hit_s = (tmo_q == TMO_LAST);
    end

    // Command/bus/response state machine with all outputs registered.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'h0;
            adr_q        <= 32'h0;
            dat_q        <= 32'h0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= 32'h0;
            rsp_status_q <= ST_OK;
            cnt_q        <= '0;
            tmo_q        <= 16'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        we_q    <= cmd_we_i;
                        sel_q   <= cmd_sel_i;
                        adr_q   <= cmd_adr_i;
                        dat_q   <= cmd_dat_i;
                        tmo_q   <= 16'h0;
                        cyc_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= BUS;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                BUS: begin
                    tmo_q <= tmo_d;
                    // err wins over ack, and ack wins over the timeout edge
                    if (wbm_err_i) begin
                        rsp_status_q <= ST_ERR;
                        rsp_dat_q    <= 32'h0;
                        cyc_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        cnt_q        <= cnt_d;
                        state_q      <= RESP;
                    end else if (wbm_ack_i) begin
                        rsp_status_q <= ST_OK;
                        rsp_dat_q    <= we_q ? 32'h0 : wbm_dat_i;
                        cyc_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        cnt_q        <= cnt_d;
                        state_q      <= RESP;
                    end else if (tmo_hit_s) begin
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_dat_q    <= 32'h0;
                        cyc_q        <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        cnt_q        <= cnt_d;
                        state_q      <= RESP;
                    end else begin
                        state_q <= BUS;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    cyc_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign txn_count_o  = cnt_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_we_o     = we_q;
    assign wbm_sel_o    = sel_q;
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;

endmodule

// File: tb/tb_la_wb_master.sv
// Scoreboard bench for la_wb_master: a main instance with an 8-cycle timeout
// and a small-counter instance used to observe counter wrap.
module tb_la_wb_master;
    import la_wb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cmd_valid, cmd_we, rsp_ready, wbm_ack, wbm_err;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat, wbm_dat_in;
    logic        cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] rsp_dat_o, wbm_adr_o, wbm_dat_o;
    logic [1:0]  rsp_status_o;
    logic [15:0] txn_count_o;
    logic [3:0]  wbm_sel_o;

    logic        w_cmd_valid, w_rsp_ready;
    logic        w_cmd_ready, w_rsp_valid, w_cyc, w_stb, w_we;
    logic [31:0] w_rsp_dat, w_adr, w_dat;
    logic [1:0]  w_status;
    logic [3:0]  w_count, w_sel;

    la_wb_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
        .rsp_status_o(rsp_status_o), .txn_count_o(txn_count_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err), .wbm_dat_i(wbm_dat_in)
    );

    la_wb_master #(.TIMEOUT_CYCLES(2), .CNT_W(4)) u_wrap (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(w_cmd_valid), .cmd_ready_o(w_cmd_ready), .cmd_we_i(1'b0),
        .cmd_sel_i(4'hF), .cmd_adr_i(32'h3000_0010), .cmd_dat_i(32'h0),
        .rsp_valid_o(w_rsp_valid), .rsp_ready_i(w_rsp_ready), .rsp_dat_o(w_rsp_dat),
        .rsp_status_o(w_status), .txn_count_o(w_count),
        .wbm_cyc_o(w_cyc), .wbm_stb_o(w_stb), .wbm_we_o(w_we),
        .wbm_sel_o(w_sel), .wbm_adr_o(w_adr), .wbm_dat_o(w_dat),
        .wbm_ack_i(1'b0), .wbm_err_i(1'b0), .wbm_dat_i(32'h0)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   exp_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    int   stb_cyc, lat, unstable;
    logic got;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] dat, input logic [1:0] st);
        exp_cnt++;
        sb.push_back('{dat: dat, st: st, cnt: 16'(exp_cnt)});
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    // Issues one command and plays the slave; returns with the response held.
    task automatic do_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input int ack_at, input int err_at,
                          input logic [31:0] rdat, output int n_stb, output int n_lat,
                          output int n_unst, output logic n_got);
        n_stb = 0; n_lat = 0; n_unst = 0; n_got = 1'b0;
        cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0; cmd_adr = ~adr; cmd_dat = ~dat; cmd_sel = ~sel; cmd_we = ~we;
        n_lat = 1;
        for (int k = 1; k <= 40 && !n_got; k++) begin
            if (wbm_stb_o) n_stb++;
            if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}
                !== {2'b11, we, sel, adr, dat}) n_unst++;
            wbm_ack = (k == ack_at); wbm_err = (k == err_at); wbm_dat_in = rdat;
            tick;
            n_lat++;
            wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat_in = 32'h0;
            if (rsp_valid_o) n_got = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        exp_cnt = 0;
        tests++;
        if ({cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctl: got rdy/rv/cyc/stb/we=%b want 10000",
                     {cmd_ready_o, rsp_valid_o, wbm_cyc_o, wbm_stb_o, wbm_we_o});
        end
        tests++;
        if ({rsp_dat_o, rsp_status_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, txn_count_o} !== 118'h0) begin
            fails++;
            $display("FAIL reset_data: got rdat=%h st=%b sel=%h adr=%h dat=%h cnt=%0d want all zero",
                     rsp_dat_o, rsp_status_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, txn_count_o);
        end
        wbm_ack = 1'b1; wbm_err = 1'b1;
        tick; tick;
        wbm_ack = 1'b0; wbm_err = 1'b0;
        tests++;
        if ({cmd_ready_o, rsp_valid_o, wbm_cyc_o} !== 3'b100 || txn_count_o !== 16'd0) begin
            fails++;
            $display("FAIL spurious_idle: got rdy/rv/cyc=%b cnt=%0d want 100 cnt=0",
                     {cmd_ready_o, rsp_valid_o, wbm_cyc_o}, txn_count_o);
        end
    endtask

    task automatic test_read;
        push_exp(32'hDEADBEEF, ST_OK);
        do_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 3, 0, 32'hDEADBEEF, stb_cyc, lat, unstable, got);
        e = sb.pop_front();
        tests++;
        if (!got || rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt) begin
            fails++;
            $display("FAIL read_rsp: got v=%b dat=%h st=%b cnt=%0d want v=1 dat=%h st=%b cnt=%0d",
                     got, rsp_dat_o, rsp_status_o, txn_count_o, e.dat, e.st, e.cnt);
        end
        tests++;
        if (stb_cyc !== 3 || unstable !== 0) begin
            fails++;
            $display("FAIL read_bus: got stb_cycles=%0d unstable=%0d want 3 and 0", stb_cyc, unstable);
        end
        consume;
        tests++;
        if ({cmd_ready_o, rsp_valid_o} !== 2'b10 || wbm_adr_o !== 32'h3000_0004) begin
            fails++;
            $display("FAIL read_release: got rdy/rv=%b adr=%h want 10 adr=30000004",
                     {cmd_ready_o, rsp_valid_o}, wbm_adr_o);
        end
    endtask

    task automatic test_write;
        push_exp(32'h0, ST_OK);
        do_txn(1'b1, 4'b0001, 32'h3000_0000, 32'h0000_00A5, 1, 0, 32'h7777_7777,
               stb_cyc, lat, unstable, got);
        e = sb.pop_front();
        tests++;
        if (!got || rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt) begin
            fails++;
            $display("FAIL write_rsp: got v=%b dat=%h st=%b cnt=%0d want v=1 dat=%h st=%b cnt=%0d",
                     got, rsp_dat_o, rsp_status_o, txn_count_o, e.dat, e.st, e.cnt);
        end
        tests++;
        if (lat !== 2 || stb_cyc !== 1 || unstable !== 0) begin
            fails++;
            $display("FAIL write_timing: got latency=%0d stb_cycles=%0d unstable=%0d want 2, 1, 0",
                     lat, stb_cyc, unstable);
        end
        consume;
    endtask

    task automatic test_timeout;
        push_exp(32'h0, ST_TIMEOUT);
        do_txn(1'b0, 4'hF, 32'h3000_0008, 32'h0, 0, 0, 32'hFFFF_FFFF, stb_cyc, lat, unstable, got);
        e = sb.pop_front();
        tests++;
        if (!got || rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt) begin
            fails++;
            $display("FAIL timeout_rsp: got v=%b dat=%h st=%b cnt=%0d want v=1 dat=%h st=%b cnt=%0d",
                     got, rsp_dat_o, rsp_status_o, txn_count_o, e.dat, e.st, e.cnt);
        end
        tests++;
        if (stb_cyc !== 8 || wbm_stb_o !== 1'b0) begin
            fails++;
            $display("FAIL timeout_len: got stb_cycles=%0d stb_now=%b want 8 and 0", stb_cyc, wbm_stb_o);
        end
        consume;
        push_exp(32'h0, ST_OK);
        do_txn(1'b1, 4'b1100, 32'h3000_000C, 32'h1122_3344, 2, 0, 32'h0, stb_cyc, lat, unstable, got);
        e = sb.pop_front();
        tests++;
        if (!got || rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt
            || stb_cyc !== 2) begin
            fails++;
            $display("FAIL after_timeout: got v=%b dat=%h st=%b cnt=%0d stb=%0d want v=1 dat=%h st=%b cnt=%0d stb=2",
                     got, rsp_dat_o, rsp_status_o, txn_count_o, stb_cyc, e.dat, e.st, e.cnt);
        end
        consume;
    endtask

    task automatic test_ack_err;
        push_exp(32'h0, ST_ERR);
        do_txn(1'b0, 4'hF, 32'h3000_0020, 32'h0, 2, 2, 32'h1234_5678, stb_cyc, lat, unstable, got);
        e = sb.pop_front();
        tests++;
        if (!got || rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt) begin
            fails++;
            $display("FAIL ack_err_rsp: got v=%b dat=%h st=%b cnt=%0d want v=1 dat=%h st=%b cnt=%0d",
                     got, rsp_dat_o, rsp_status_o, txn_count_o, e.dat, e.st, e.cnt);
        end
        consume;
        push_exp(32'h55AA_33CC, ST_OK);
        do_txn(1'b0, 4'hF, 32'h3000_0024, 32'h0, 8, 0, 32'h55AA_33CC, stb_cyc, lat, unstable, got);
        e = sb.pop_front();
        tests++;
        if (!got || rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt
            || stb_cyc !== 8) begin
            fails++;
            $display("FAIL ack_on_timeout: got v=%b dat=%h st=%b cnt=%0d stb=%0d want v=1 dat=%h st=%b cnt=%0d stb=8",
                     got, rsp_dat_o, rsp_status_o, txn_count_o, stb_cyc, e.dat, e.st, e.cnt);
        end
        consume;
    endtask

    task automatic test_reset_mid;
        cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0030; cmd_dat = 32'h0; cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_cnt = 0;
        tests++;
        if ({wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o} !== 4'b0001 || txn_count_o !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid: got cyc/stb/rv/rdy=%b cnt=%0d want 0001 cnt=0",
                     {wbm_cyc_o, wbm_stb_o, rsp_valid_o, cmd_ready_o}, txn_count_o);
        end
        tick; tick;
        tests++;
        if (rsp_valid_o !== 1'b0 || wbm_cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got rv=%b cyc=%b want 0 and 0", rsp_valid_o, wbm_cyc_o);
        end
    endtask

    task automatic test_back_to_back;
        int accepts = 0;
        int bus_cnt = 0;
        int rsps = 0;
        int extra = 0;
        logic prev_stb;
        cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0040; cmd_dat = 32'h0;
        wbm_dat_in = 32'hA5A5_0F0F;
        for (int i = 0; i < 4; i++) push_exp(32'hA5A5_0F0F, ST_OK);
        cmd_valid = 1'b1; rsp_ready = 1'b1; wbm_ack = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (cmd_valid && cmd_ready_o) accepts++;
            prev_stb = wbm_stb_o;
            tick;
            if (wbm_stb_o && !prev_stb) bus_cnt++;
            if (accepts == 4) cmd_valid = 1'b0;
            if (rsp_valid_o) begin
                rsps++;
                if (sb.size() == 0) begin
                    extra++;
                end else begin
                    e = sb.pop_front();
                    tests++;
                    if (rsp_dat_o !== e.dat || rsp_status_o !== e.st || txn_count_o !== e.cnt) begin
                        fails++;
                        $display("FAIL b2b_rsp%0d: got dat=%h st=%b cnt=%0d want dat=%h st=%b cnt=%0d",
                                 rsps, rsp_dat_o, rsp_status_o, txn_count_o, e.dat, e.st, e.cnt);
                    end
                end
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0; wbm_ack = 1'b0; wbm_dat_in = 32'h0;
        tests++;
        if (bus_cnt !== 4 || rsps !== 4 || extra !== 0 || txn_count_o !== 16'd4) begin
            fails++;
            $display("FAIL b2b_count: got bus=%0d rsps=%0d extra=%0d cnt=%0d want 4 4 0 4",
                     bus_cnt, rsps, extra, txn_count_o);
        end
        sb.delete();
    endtask

    task automatic test_wrap;
        int n = 0;
        logic [3:0] want;
        w_cmd_valid = 1'b1; w_rsp_ready = 1'b1;
        for (int c = 0; c < 200 && n < 17; c++) begin
            tick;
            if (w_rsp_valid) begin
                n++;
                want = 4'(n);
                tests++;
                if (w_count !== want || w_status !== ST_TIMEOUT) begin
                    fails++;
                    $display("FAIL wrap_cnt%0d: got cnt=%0d st=%b want cnt=%0d st=10", n, w_count, w_status, want);
                end
            end
        end
        w_cmd_valid = 1'b0; w_rsp_ready = 1'b0;
        tests++;
        if (n !== 17) begin
            fails++;
            $display("FAIL wrap_budget: got %0d responses want 17", n);
        end
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; rsp_ready = 1'b0;
        wbm_ack = 1'b0; wbm_err = 1'b0; cmd_sel = 4'h0; cmd_adr = 32'h0;
        cmd_dat = 32'h0; wbm_dat_in = 32'h0; w_cmd_valid = 1'b0; w_rsp_ready = 1'b0;
        test_reset;
        test_read;
        test_write;
        test_timeout;
        test_ack_err;
        test_reset_mid;
        test_back_to_back;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
